// File: rtl/bk_adder_pkg.sv
// -----------------------------------------------------------------------------
// bk_adder_pkg
// Shared definitions for the Brent-Kung prefix adder.
//   BK_N    : default operand width
//   tgp_t   : (group generate, group propagate) pair carried through the tree
//   bk_log2 : constant log2 used to size the prefix-tree generate loops
// -----------------------------------------------------------------------------
package bk_adder_pkg;

    localparam int BK_N = 32;

    typedef struct packed {
        logic g;
        logic p;
    } tgp_t;

    // Smallest r with 2^r >= n; exact log2 for the power-of-two widths used here.
    function automatic int bk_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bk_adder_prefix_cell.sv
// -----------------------------------------------------------------------------
// bk_prefix_cell
// Black cell of the prefix tree: (G,P) o (G',P') = (G | P&G', P&P').
// Ports:
//   i_hi : (G,P) of the more significant span
//   i_lo : (G',P') of the adjacent less significant span
//   o_gp : combined (G,P) covering both spans
// -----------------------------------------------------------------------------
module bk_prefix_cell
    import bk_adder_pkg::*;
(
    input  tgp_t i_hi,
    input  tgp_t i_lo,
    output tgp_t o_gp
);

    assign o_gp.g = i_hi.g | (i_hi.p & i_lo.g);
    assign o_gp.p = i_hi.p & i_lo.p;

endmodule

// File: rtl/bk_adder.sv
// -----------------------------------------------------------------------------
// bk_adder
// Brent-Kung parallel-prefix adder, {Cout, Y} = A + B + Cin, registered output.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; clears Y and Cout immediately
//   A, B  : N-bit addends
//   Cin   : carry-in (weight 2^0)
//   Y     : N-bit registered sum
//   Cout  : registered carry out of bit N-1
// Parameter N: power of two, 2..64 (elaboration error otherwise).
// Build option BK_ADDER_INREG_EN: when defined, A/B/Cin are also registered
// (reset to 0) giving 2-cycle latency; otherwise latency is 1 cycle.
// -----------------------------------------------------------------------------
module bk_adder
    import bk_adder_pkg::*;
#(
    parameter int N = BK_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Y,
    output logic         Cout
);

    localparam int L = bk_log2(N);

    if ((N < 2) || (N > 64) || ((1 << L) != N)) begin : g_bad_width
        $error("bk_adder: N must be a power of two between 2 and 64");
    end

    // ------------------------------------------------------------------
    // Operand source: optional input register stage
    // ------------------------------------------------------------------
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic         w_cin;

`ifdef BK_ADDER_INREG_EN
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic         r_cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= 1'b0;
        end else begin
            r_a   <= A;
            r_b   <= B;
            r_cin <= Cin;
        end
    end

    assign w_a   = r_a;
    assign w_b   = r_b;
    assign w_cin = r_cin;
`else
    assign w_a   = A;
    assign w_b   = B;
    assign w_cin = Cin;
`endif

    // ------------------------------------------------------------------
    // Prefix tree. Stage 0 is the bitwise (g,p); stages 1..L are the
    // up-sweep, stages L+1..2L-1 the down-sweep. After the last stage
    // every bit i holds the group generate over [i:-1], i.e. carry C_i.
    // Nodes not combined at a level pass their pair straight through so
    // every node is driven at every stage.
    // ------------------------------------------------------------------
    for (genvar s = 0; s < 2 * L; s++) begin : g_stage
        logic [N-1:0] w_g;
        logic [N-1:0] w_p;

        if (s == 0) begin : g_pre
            logic [N-1:0] w_g_raw;
            assign w_g_raw = w_a & w_b;
            assign w_p     = w_a ^ w_b;
            // Cin is a generate at bit -1, folded into node 0.
            if (N > 1) begin : g_upper
                assign w_g[N-1:1] = w_g_raw[N-1:1];
            end
            assign w_g[0] = w_g_raw[0] | (w_p[0] & w_cin);
        end else begin : g_lvl
            for (genvar i = 0; i < N; i++) begin : g_bit
                localparam bit UP   = (s <= L);
                // Up-sweep stage s works on span 2^(s-1); down-sweep stage
                // s works on span 2^(2L-1-s), finest span last.
                localparam int K    = UP ? (s - 1) : (2 * L - 1 - s);
                localparam int SPAN = 1 << K;
                localparam bit ACT  = UP ?
                    (((i + 1) % (2 * SPAN)) == 0) :
                    ((((i + 1) % (2 * SPAN)) == SPAN) && ((i + 1) > 2 * SPAN));

                if (ACT) begin : g_cell
                    tgp_t w_hi;
                    tgp_t w_lo;
                    tgp_t w_out;

                    assign w_hi = '{g: g_stage[s-1].w_g[i],      p: g_stage[s-1].w_p[i]};
                    assign w_lo = '{g: g_stage[s-1].w_g[i-SPAN], p: g_stage[s-1].w_p[i-SPAN]};

                    bk_prefix_cell u_cell (
                        .i_hi (w_hi),
                        .i_lo (w_lo),
                        .o_gp (w_out)
                    );

                    assign w_g[i] = w_out.g;
                    assign w_p[i] = w_out.p;
                end else begin : g_pass
                    assign w_g[i] = g_stage[s-1].w_g[i];
                    assign w_p[i] = g_stage[s-1].w_p[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sum: Y_0 = p_0 ^ Cin, Y_i = p_i ^ C_(i-1); Cout = C_(N-1)
    // ------------------------------------------------------------------
    logic [N-1:0] w_c;
    logic [N-1:0] w_p0;
    logic [N-1:0] w_carry_in;
    logic [N-1:0] w_sum;
    logic         w_unused_p;

    assign w_c        = g_stage[2*L-1].w_g;
    assign w_p0       = w_a ^ w_b;
    assign w_carry_in = {w_c[N-2:0], w_cin};
    assign w_sum      = w_p0 ^ w_carry_in;

    // Final group-propagate values have no consumer.
    assign w_unused_p = ^g_stage[2*L-1].w_p;

    logic [N-1:0] r_y;
    logic         r_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_y    <= w_sum;
            r_cout <= w_c[N-1];
        end
    end

    assign Y    = r_y;
    assign Cout = r_cout;

endmodule

// File: tb/tb_bk_adder.sv
// -----------------------------------------------------------------------------
// tb_bk_adder
// Drives a 32-bit and an 8-bit bk_adder with the same stimulus (the 8-bit one
// sees the low byte of each operand) and compares every output against
// queued results computed with plain integer addition.
// -----------------------------------------------------------------------------
module tb_bk_adder;

`ifdef BK_ADDER_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic [31:0] y32;
    logic        cout32;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [7:0]  y8;
    logic        cout8;
    logic        cin = 1'b0;

    bk_adder #(.N(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a32),
        .B     (b32),
        .Cin   (cin),
        .Y     (y32),
        .Cout  (cout32)
    );

    bk_adder #(.N(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a8),
        .B     (b8),
        .Cin   (cin),
        .Y     (y8),
        .Cout  (cout8)
    );

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    logic [8:0]  exp8_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int unsigned s;
        s = int'(a) + int'(b) + int'(c);
        return s[8:0];
    endfunction

    function automatic logic [32:0] model32(input logic [31:0] a, input logic [31:0] b, input logic c);
        longint unsigned s;
        s = longint'(a) + longint'(b) + longint'(c);
        return s[32:0];
    endfunction

    // After reset the optional input stage holds zeros, so the first
    // LAT-1 results out of reset are 0 + 0 + 0.
    task automatic flush_queues();
        exp_q.delete();
        exp8_q.delete();
        for (int i = 0; i < LAT - 1; i++) begin
            exp_q.push_back(33'd0);
            exp8_q.push_back(9'd0);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [32:0] e32);
        @(negedge clk);
        a32 = a;
        b32 = b;
        a8  = a[7:0];
        b8  = b[7:0];
        cin = c;
        @(posedge clk);
        #1;
        exp_q.push_back(e32);
        exp8_q.push_back(model8(a[7:0], b[7:0], c));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [32:0] e32;
        logic [8:0]  e8;
        // Nonzero inputs while reset is held from time zero, before any edge.
        a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678; a8 = 8'hEF; b8 = 8'h78; cin = 1'b1;
        #2;
        checks += 2;
        if ({cout32, y32} !== 33'd0) begin
            errors++;
            $display("FAIL reset_initial_32: got %h expected %h", {cout32, y32}, 33'd0);
        end
        if ({cout8, y8} !== 9'd0) begin
            errors++;
            $display("FAIL reset_initial_8: got %h expected %h", {cout8, y8}, 9'd0);
        end

        @(negedge clk);
        rst_n = 1'b1;
        flush_queues();
        for (int k = 0; k < 3; k++) begin
            step(32'd5 + 32'(k), 32'd6, 1'b0, model32(32'd5 + 32'(k), 32'd6, 1'b0));
            if (exp_q.size() == LAT) begin
                e32 = exp_q.pop_front();
                e8  = exp8_q.pop_front();
                checks += 2;
                if ({cout32, y32} !== e32) begin
                    errors++;
                    $display("FAIL release_32: got %h expected %h", {cout32, y32}, e32);
                end
                if ({cout8, y8} !== e8) begin
                    errors++;
                    $display("FAIL release_8: got %h expected %h", {cout8, y8}, e8);
                end
            end
        end

        // Asynchronous assertion mid-cycle, away from any clock edge.
        step(32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 33'h1_0000_0003);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if ({cout32, y32} !== 33'd0) begin
            errors++;
            $display("FAIL reset_async_32: got %h expected %h", {cout32, y32}, 33'd0);
        end
        if ({cout8, y8} !== 9'd0) begin
            errors++;
            $display("FAIL reset_async_8: got %h expected %h", {cout8, y8}, 9'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        flush_queues();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [32:0] e;
    } vec_t;

    task automatic test_directed();
        vec_t        v[10];
        logic [32:0] e32;
        logic [8:0]  e8;
        v[0] = '{32'h0000_000A, 32'h0000_000B, 1'b0, 33'h0_0000_0015};
        v[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF};
        v[2] = '{32'hFFFF_FFF0, 32'h0000_000F, 1'b1, 33'h1_0000_0000};
        v[3] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 33'h0_FFFF_FFFF};
        v[4] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 33'h0_FFFF_FFFF};
        v[5] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 33'h1_0000_0000};
        v[6] = '{32'h1234_5678, 32'h8765_4321, 1'b1, 33'h0_9999_999A};
        v[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001};
        v[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000};
        v[9] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000};
        // Operands change every cycle, so this is also the back-to-back case.
        for (int k = 0; k < 10; k++) begin
            step(v[k].a, v[k].b, v[k].c, v[k].e);
            if (exp_q.size() == LAT) begin
                e32 = exp_q.pop_front();
                e8  = exp8_q.pop_front();
                checks += 2;
                if ({cout32, y32} !== e32) begin
                    errors++;
                    $display("FAIL directed_32: got %h expected %h", {cout32, y32}, e32);
                end
                if ({cout8, y8} !== e8) begin
                    errors++;
                    $display("FAIL directed_8: got %h expected %h", {cout8, y8}, e8);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [32:0] e32;
        logic [8:0]  e8;
        for (int k = 0; k < 10000 + LAT - 1; k++) begin
            if (k < 10000) begin
                a = $urandom();
                b = $urandom();
                c = 1'($urandom_range(0, 1));
                // Bias some operands toward long carry chains.
                if ($urandom_range(0, 7) == 0) b = ~a;
            end else begin
                a = '0;
                b = '0;
                c = 1'b0;
            end
            step(a, b, c, model32(a, b, c));
            if (exp_q.size() == LAT) begin
                e32 = exp_q.pop_front();
                e8  = exp8_q.pop_front();
                checks += 2;
                if ({cout32, y32} !== e32) begin
                    errors++;
                    $display("FAIL random_32: got %h expected %h", {cout32, y32}, e32);
                end
                if ({cout8, y8} !== e8) begin
                    errors++;
                    $display("FAIL random_8: got %h expected %h", {cout8, y8}, e8);
                end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
